// File: rtl/pixel_plotter_if.sv
// Point-request channel into the pixel plotter.
// The master drives a point and its operation. The slave answers with ready.
interface pixel_plotter_if;
  logic       pt_valid;
  logic       pt_ready;
  logic [9:0] pt_x;
  logic [8:0] pt_y;
  logic       pt_erase;

  modport master (
    output pt_valid,
    output pt_x,
    output pt_y,
    output pt_erase,
    input  pt_ready
  );

  modport slave (
    input  pt_valid,
    input  pt_x,
    input  pt_y,
    input  pt_erase,
    output pt_ready
  );
endinterface

// File: rtl/pixel_plotter.sv
// 1-bpp framebuffer plotter. Each accepted point updates one pixel through a
// read-modify-write of the 32-bit word that holds it. A clear request zeroes
// the whole framebuffer, writing one word per cycle.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting; accepts a point or a clear request
//   READ  | BRAM read of the word holding the pixel
//   WAIT  | read data arrives; modified word is registered
//   WRITE | modified word written back, point counted
//   CLEAR | zero-word writes sweeping the whole framebuffer
module pixel_plotter #(
  parameter int H_PIX = 640,
  parameter int V_PIX = 480
) (
  input  logic                  clk_25MHz,
  input  logic                  reset,
  pixel_plotter_if.slave        pt_if,
  input  logic                  clr_req_i,
  output logic                  busy_o,
  output logic                  oob_err_o,
  output logic [15:0]           pt_count_o,
  output logic                  bram_en_o,
  output logic                  bram_we_o,
  output logic [15:0]           bram_addr_o,
  output logic [31:0]           bram_wdata_o,
  input  logic [31:0]           bram_rdata_i
);

  localparam int WORDS_PER_LINE = H_PIX / 32;
  localparam int LAST_WORD      = (H_PIX * V_PIX) / 32 - 1;

  localparam logic [15:0] WPL      = 16'(WORDS_PER_LINE);
  localparam logic [15:0] CLR_LAST = 16'(LAST_WORD);
  localparam logic [10:0] X_LIM    = 11'(H_PIX);
  localparam logic [9:0]  Y_LIM    = 10'(V_PIX);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_CLEAR = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  bit_q, bit_d;
  logic        erase_q, erase_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] word_q, word_d;
  logic [15:0] count_q, count_d;
  logic        oob_q, oob_d;
  logic [15:0] left_q, left_d;

  logic        in_range;
  logic [15:0] word_idx;
  logic [15:0] pt_addr;

  // Address of the word holding the requested pixel (row-major, 4-byte words).
  assign in_range = ({1'b0, pt_if.pt_x} < X_LIM) && ({1'b0, pt_if.pt_y} < Y_LIM);
  assign word_idx = 16'(pt_if.pt_y) * WPL + 16'(pt_if.pt_x[9:5]);
  assign pt_addr  = {word_idx[13:0], 2'b00};

  // State register and datapath registers; reset abandons any operation.
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      erase_q <= 1'b0;
      addr_q  <= '0;
      word_q  <= '0;
      count_q <= '0;
      oob_q   <= 1'b0;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      erase_q <= erase_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      count_q <= count_d;
      oob_q   <= oob_d;
      left_q  <= left_d;
    end
  end

  // Next-state and datapath update. A clear request wins over a pending point.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    erase_d = erase_q;
    addr_d  = addr_q;
    word_d  = word_q;
    count_d = count_q;
    oob_d   = 1'b0;
    left_d  = left_q;
    case (state_q)
      S_IDLE: begin
        if (clr_req_i) begin
          state_d = S_CLEAR;
          count_d = '0;
          addr_d  = '0;
          left_d  = CLR_LAST;
        end else if (pt_if.pt_valid) begin
          if (in_range) begin
            state_d = S_READ;
            addr_d  = pt_addr;
            bit_d   = pt_if.pt_x[4:0];
            erase_d = pt_if.pt_erase;
          end else begin
            oob_d = 1'b1;
          end
        end
      end
      S_READ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        word_d        = bram_rdata_i;
        word_d[bit_q] = ~erase_q;
        state_d       = S_WRITE;
      end
      S_WRITE: begin
        count_d = count_q + 16'd1;
        state_d = S_IDLE;
      end
      S_CLEAR: begin
        // left_q counts down the words still to write after this one.
        if (left_q == 16'd0) begin
          state_d = S_IDLE;
        end else begin
          addr_d = addr_q + 16'd4;
          left_d = left_q - 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    pt_if.pt_ready = 1'b0;
    bram_en_o      = 1'b0;
    bram_we_o      = 1'b0;
    bram_wdata_o   = '0;
    case (state_q)
      S_IDLE: begin
        pt_if.pt_ready = ~clr_req_i;
      end
      S_READ: begin
        bram_en_o = 1'b1;
      end
      S_WRITE: begin
        bram_en_o    = 1'b1;
        bram_we_o    = 1'b1;
        bram_wdata_o = word_q;
      end
      S_CLEAR: begin
        bram_en_o = 1'b1;
        bram_we_o = 1'b1;
      end
      default: begin
        bram_en_o = 1'b0;
      end
    endcase
  end

  assign busy_o      = (state_q != S_IDLE);
  assign oob_err_o   = oob_q;
  assign pt_count_o  = count_q;
  assign bram_addr_o = addr_q;

endmodule

// File: tb/tb_pixel_plotter.sv
// Bench for pixel_plotter: a BRAM model backs the DUT, and a reference
// framebuffer predicts every BRAM write. The predictions go into a queue and
// are matched against the DUT's writes.
module tb_pixel_plotter;

  localparam int NWORDS = 9600;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        reset;
  logic        clr_req;
  logic        busy;
  logic        oob_err;
  logic [15:0] pt_count;
  logic        bram_en;
  logic        bram_we;
  logic [15:0] bram_addr;
  logic [31:0] bram_wdata;
  logic [31:0] bram_rdata;

  pixel_plotter_if pt_if ();

  pixel_plotter dut (
    .clk_25MHz    (clk),
    .reset        (reset),
    .pt_if        (pt_if.slave),
    .clr_req_i    (clr_req),
    .busy_o       (busy),
    .oob_err_o    (oob_err),
    .pt_count_o   (pt_count),
    .bram_en_o    (bram_en),
    .bram_we_o    (bram_we),
    .bram_addr_o  (bram_addr),
    .bram_wdata_o (bram_wdata),
    .bram_rdata_i (bram_rdata)
  );

  logic [31:0] fb      [0:NWORDS-1];
  logic [31:0] ref_fb  [0:NWORDS-1];
  wr_t         exp_q   [$];
  int          n_checks;
  int          n_errors;
  int          busy_cyc;
  int          wr_cnt;
  logic [15:0] exp_count;

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // BRAM model: read data appears the cycle after the read.
  always @(posedge clk) begin
    if (bram_en && (bram_addr[15:2] < 14'(NWORDS))) begin
      if (bram_we) fb[bram_addr[15:2]] <= bram_wdata;
      else         bram_rdata <= fb[bram_addr[15:2]];
    end
  end

  // Monitor: every BRAM access must match the next predicted write.
  always @(negedge clk) begin
    if (!reset) begin
      if (busy) busy_cyc++;
      if (bram_en && bram_we) begin
        wr_cnt++;
        chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          chk("wr_addr", 32'(bram_addr), 32'(exp_q[0].addr));
          chk("wr_data", bram_wdata, exp_q[0].data);
          void'(exp_q.pop_front());
        end
      end else if (bram_en) begin
        chk("rd_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0)
          chk("rd_addr", 32'(bram_addr), 32'(exp_q[0].addr));
      end
    end
  end

  task automatic push_clear();
    for (int i = 0; i < NWORDS; i++) begin
      exp_q.push_back({16'(i * 4), 32'h0});
      ref_fb[i] = 32'h0;
    end
  endtask

  task automatic send_point(input int x, input int y, input logic erase);
    int n;
    int idx;
    logic [31:0] w;
    logic [15:0] cnt_before;
    bit ok;
    ok = (x < 640) && (y < 480);
    cnt_before = pt_count;
    pt_if.pt_valid = 1'b1;
    pt_if.pt_x     = 10'(x);
    pt_if.pt_y     = 9'(y);
    pt_if.pt_erase = erase;
    if (ok) begin
      idx = y * 20 + x / 32;
      w = ref_fb[idx];
      w[x % 32] = ~erase;
      ref_fb[idx] = w;
      exp_q.push_back({16'(idx * 4), w});
      exp_count = exp_count + 16'd1;
    end
    #1 chk("ready_at_accept", 32'(pt_if.pt_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    pt_if.pt_valid = 1'b0;
    if (ok) begin
      n = 1;
      while (!pt_if.pt_ready && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("ready_gap", 32'(n), 32'd4);
      chk("pt_count", 32'(pt_count), 32'(exp_count));
    end else begin
      chk("oob_pulse", 32'(oob_err), 32'd1);
      chk("oob_ready", 32'(pt_if.pt_ready), 32'd1);
      @(negedge clk);
      chk("oob_pulse_end", 32'(oob_err), 32'd0);
      chk("oob_count", 32'(pt_count), 32'(cnt_before));
    end
  endtask

  initial begin
    int n;
    n_checks  = 0;
    n_errors  = 0;
    busy_cyc  = 0;
    wr_cnt    = 0;
    exp_count = '0;
    bram_rdata = '0;
    for (int i = 0; i < NWORDS; i++) begin
      fb[i]     = 32'h0;
      ref_fb[i] = 32'h0;
    end
    reset          = 1'b1;
    clr_req        = 1'b0;
    pt_if.pt_valid = 1'b0;
    pt_if.pt_x     = '0;
    pt_if.pt_y     = '0;
    pt_if.pt_erase = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_oob",   32'(oob_err), 32'd0);
    chk("rst_count", 32'(pt_count), 32'd0);
    chk("rst_en",    32'(bram_en), 32'd0);
    chk("rst_we",    32'(bram_we), 32'd0);
    chk("rst_addr",  32'(bram_addr), 32'd0);
    chk("rst_wdata", bram_wdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(pt_if.pt_ready), 32'd1);

    // Clear interrupted by reset at word 100.
    push_clear();
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    n = 0;
    while (bram_addr != 16'd400 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("clr_word100", 32'(bram_addr), 32'd400);
    #2 reset = 1'b1;
    #1;
    chk("midclr_en",   32'(bram_en), 32'd0);
    chk("midclr_busy", 32'(busy), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midclr_ready", 32'(pt_if.pt_ready), 32'd1);
    chk("midclr_count", 32'(pt_count), 32'd0);
    chk("midclr_busy2", 32'(busy), 32'd0);

    // A point first, so the clear must bring the count back to 0.
    send_point(3, 3, 1'b0);

    // Clear and point on the same edge: the clear wins.
    push_clear();
    exp_count = '0;
    busy_cyc = 0;
    wr_cnt = 0;
    clr_req = 1'b1;
    pt_if.pt_valid = 1'b1;
    pt_if.pt_x = 10'd5;
    pt_if.pt_y = 9'd5;
    pt_if.pt_erase = 1'b0;
    @(negedge clk);
    clr_req = 1'b0;
    pt_if.pt_valid = 1'b0;
    n = 0;
    while (busy && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk("clr_done", 32'(busy), 32'd0);
    chk("clr_busy_cycles", 32'(busy_cyc), 32'd9600);
    chk("clr_writes", 32'(wr_cnt), 32'd9600);
    chk("clr_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("clr_count", 32'(pt_count), 32'd0);

    // Directed points.
    send_point(0, 0, 1'b0);
    send_point(639, 479, 1'b0);
    fb[21] = 32'hFFFF_FFFF;
    ref_fb[21] = 32'hFFFF_FFFF;
    send_point(37, 1, 1'b1);
    send_point(640, 0, 1'b0);
    send_point(0, 480, 1'b1);
    send_point(31, 2, 1'b0);
    send_point(32, 2, 1'b0);
    send_point(31, 2, 1'b1);

    // Random points against the reference framebuffer.
    for (int i = 0; i < 40; i++)
      send_point(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
                 1'($urandom_range(0, 1)));

    repeat (2) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_count", 32'(pt_count), 32'(exp_count));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pixel_plotter.md
PIXEL_PLOTTER -- requirements
Module: pixel_plotter

Interface
REQ-001 Parameter H_PIX, default 640, SHALL set the visible pixels per line (multiple of 32).
REQ-002 Parameter V_PIX, default 480, SHALL set the visible lines per frame.
REQ-003 clk_25MHz  input  1  SHALL be the clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the reset, asynchronous, active-high.
REQ-005 pt_valid  input  1  SHALL indicate that a point request is present.
REQ-006 pt_ready  output  1  SHALL indicate that a point request can be accepted.
REQ-007 pt_x  input  10  SHALL give the point column, 0 = leftmost.
REQ-008 pt_y  input  9  SHALL give the point row, 0 = top.
REQ-009 pt_erase  input  1  SHALL select the operation: 1 = clear the pixel, 0 = set it.
REQ-010 clr_req  input  1  SHALL request a full-framebuffer clear.
REQ-011 busy  output  1  SHALL be high whenever the block is not in IDLE.
REQ-012 oob_err  output  1  SHALL carry a one-cycle pulse when a point is rejected as out of range.
REQ-013 pt_count  output  16  SHALL count points written.
REQ-014 bram_en  output  1  SHALL be the framebuffer port enable.
REQ-015 bram_we  output  1  SHALL be the framebuffer write enable (full 32-bit word).
REQ-016 bram_addr  output  16  SHALL be the framebuffer byte address, always a multiple of 4.
REQ-017 bram_wdata  output  32  SHALL be the framebuffer write data.
REQ-018 bram_rdata  input  32  SHALL be the framebuffer read data, valid the cycle after a read is issued.

Function
REQ-019 Framebuffer format SHALL be 1 bit per pixel, 32 pixels per word, row-major.
REQ-020 Bit k of a word SHALL hold the pixel at column 32*w+k, so bit 0 is the leftmost pixel of the group.
REQ-021 Word index SHALL be pt_y*(H_PIX/32) + pt_x[9:5].
REQ-022 bram_addr SHALL be word index*4, so the default last word is at byte address 38396.
REQ-023 The FSM SHALL have exactly five states: IDLE, READ, WAIT, WRITE, CLEAR.
REQ-024 pt_ready SHALL equal (state==IDLE && !clr_req).
REQ-025 A point SHALL be accepted when pt_valid && pt_ready on a clock edge; pt_x, pt_y and pt_erase are captured on that edge.
REQ-026 If an accepted point has pt_x>=H_PIX or pt_y>=V_PIX, the block SHALL pulse oob_err in the next cycle, stay in IDLE, issue no BRAM access and leave pt_count unchanged.
REQ-027 For an in-range point, IDLE SHALL transition to READ.
REQ-028 READ (1 cycle): bram_en=1, bram_we=0, bram_addr = computed address; then go to WAIT.
REQ-029 WAIT (1 cycle): register bram_rdata with bit pt_x[4:0] forced to 0 (erase) or 1 (set); all other bits unchanged; then go to WRITE.
REQ-030 WRITE (1 cycle): bram_en=1, bram_we=1, same address, bram_wdata = modified word; pt_count increments (wraps 65535->0); then go to IDLE.
REQ-031 Throughput SHALL be one point per 4 cycles; pt_ready SHALL be low for 3 cycles after each in-range acceptance.
REQ-032 In IDLE with clr_req=1, the block SHALL enter CLEAR; clr_req has priority over pt_valid on the same edge, and no point is accepted.
REQ-033 On entering CLEAR, pt_count SHALL reset to 0.
REQ-034 CLEAR SHALL write one zero word per cycle (bram_en=1, bram_we=1, bram_wdata=0) at addresses 0,4,...,(H_PIX*V_PIX/32-1)*4, then return to IDLE; default length 9600 cycles.
REQ-035 clr_req and pt_valid SHALL be ignored outside IDLE; a clr_req still high on return to IDLE starts a new clear.
REQ-036 bram_en and bram_we SHALL be 0 in IDLE and WAIT.
REQ-037 bram_addr and bram_wdata SHALL be don't-care when bram_en=0.

Reset
REQ-038 On reset assertion at any time, including mid-CLEAR or mid read-modify-write, the block SHALL immediately go to IDLE with busy=0, oob_err=0, pt_count=0, bram_en=0, bram_we=0, bram_addr=0, bram_wdata=0; the interrupted operation is abandoned.
REQ-039 pt_ready SHALL be 1 in the first cycle after reset deassertion if clr_req=0.

Verification
REQ-040 Reset pulse during CLEAR word 100 -> bram_en=0 immediately; after release pt_ready=1, pt_count=0, busy=0.
REQ-041 Point (0,0) set with rdata=0x00000000 -> read at addr 0, then write addr 0 with wdata=0x00000001; pt_count=1; pt_ready high again 4 cycles after acceptance.
REQ-042 Point (639,479) set with rdata=0 -> write addr 38396 with wdata=0x80000000.
REQ-043 Point (37,1) erase with rdata=0xFFFFFFFF -> write addr 84 with wdata=0xFFFFFFDF.
REQ-044 Point (640,0) -> one-cycle oob_err pulse, no bram_en, pt_count unchanged, pt_ready stays high.
REQ-045 clr_req and pt_valid asserted on the same IDLE edge -> exactly 9600 consecutive zero writes at 0..38396 step 4; busy high 9600 cycles; point not accepted; pt_count=0.
